// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_ctrl_pkg;

    localparam int FUN_W = 4;

    localparam logic [7:0] CMD_OP_DEF    = 8'hCC;
    localparam logic [7:0] CMD_REUSE_DEF = 8'hDD;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_A   = 3'd1,
        GET_B   = 3'd2,
        GET_FUN = 3'd3,
        RUN     = 3'd4,
        SEND_LO = 3'd5,
        SEND_HI = 3'd6
    } state_e;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// RX stream, TX handshake and ALU operand/result bundle of the command sequencer.
interface alu_cmd_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
);
    import alu_ctrl_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [FUN_W-1:0]  alu_fun;
    logic              alu_en;
    logic [OUT_W-1:0]  alu_out;
    logic              busy;
    logic              err;

    modport slave (
        input  rx_data, rx_valid, tx_ready, alu_out,
        output tx_data, tx_valid, alu_a, alu_b, alu_fun, alu_en, busy, err
    );

    modport master (
        output rx_data, rx_valid, tx_ready, alu_out,
        input  tx_data, tx_valid, alu_a, alu_b, alu_fun, alu_en, busy, err
    );

endinterface

// File: rtl/alu_cmd_ctrl_frame_timer.sv
// Saturating inter-byte counter; timeout flags the last cycle of a TMO_CYC-cycle silence.
module frame_timer #(
    parameter int TMO_CYC = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int CW = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = en && (cnt == LAST);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command frame sequencer for the shared ALU. Define ALU_CTRL_TMO_EN to abort stalled frames
// after TMO_CYC idle cycles; otherwise the GET_* states wait indefinitely.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                OUT_W     = 16,
    parameter logic [DATA_W-1:0] CMD_OP    = CMD_OP_DEF,
    parameter logic [DATA_W-1:0] CMD_REUSE = CMD_REUSE_DEF,
    parameter int                ALU_LAT   = 1,
    parameter int                TMO_CYC   = 1023
) (
    input logic clk,
    input logic rst,
    alu_cmd_ctrl_if.slave bus
);
    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

    state_e                  state;
    logic [2:0]              lat_cnt;
    logic [OUT_W-DATA_W-1:0] res_hi;
    logic [DATA_W-1:0]       tx_data, alu_a, alu_b;
    logic [FUN_W-1:0]        alu_fun;
    logic                    tx_valid, alu_en;
    logic                    in_get, tmo, err;

    assign in_get = (state == GET_A) || (state == GET_B) || (state == GET_FUN);

`ifdef ALU_CTRL_TMO_EN
    logic tmr_timeout;

    frame_timer #(.TMO_CYC(TMO_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_get || bus.rx_valid),
        .en      (in_get),
        .timeout (tmr_timeout)
    );

    assign tmo = tmr_timeout && !bus.rx_valid;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        err = 1'b0;
        if (!rst) begin
            if (bus.rx_valid) begin
                case (state)
                    IDLE:                  err = (bus.rx_data != CMD_OP) && (bus.rx_data != CMD_REUSE);
                    RUN, SEND_LO, SEND_HI: err = 1'b1;
                    default:               err = 1'b0;
                endcase
            end
            if (tmo) err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            res_hi   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_fun  <= '0;
            alu_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == CMD_OP)         state <= GET_A;
                        else if (bus.rx_data == CMD_REUSE) state <= GET_FUN;
                    end
                end
                GET_A: begin
                    if (bus.rx_valid) begin
                        alu_a <= bus.rx_data;
                        state <= GET_B;
                    end else if (tmo) begin
                        state <= IDLE;
                    end
                end
                GET_B: begin
                    if (bus.rx_valid) begin
                        alu_b <= bus.rx_data;
                        state <= GET_FUN;
                    end else if (tmo) begin
                        state <= IDLE;
                    end
                end
                GET_FUN: begin
                    if (bus.rx_valid) begin
                        alu_fun <= bus.rx_data[FUN_W-1:0];
                        alu_en  <= 1'b1;
                        lat_cnt <= '0;
                        state   <= RUN;
                    end else if (tmo) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // alu_en window first, then one capture cycle once it has dropped
                    if (alu_en) begin
                        lat_cnt <= lat_cnt + 3'd1;
                        if (lat_cnt == LAT_LAST) alu_en <= 1'b0;
                    end else begin
                        tx_data  <= bus.alu_out[DATA_W-1:0];
                        res_hi   <= bus.alu_out[OUT_W-1:DATA_W];
                        tx_valid <= 1'b1;
                        state    <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (bus.tx_ready) begin
                        tx_data <= res_hi;
                        state   <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (bus.tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign bus.alu_a    = alu_a;
    assign bus.alu_b    = alu_b;
    assign bus.alu_fun  = alu_fun;
    assign bus.alu_en   = alu_en;
    assign bus.busy     = (state != IDLE);
    assign bus.err      = err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: table-driven frames, byte scoreboard on TX, and corner-case sequences.
module tb_alu_cmd_ctrl;
    import alu_ctrl_pkg::*;

    localparam int ALU_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_ctrl_if #(.DATA_W(8), .OUT_W(16)) bus ();

    alu_cmd_ctrl #(
        .DATA_W(8), .OUT_W(16), .CMD_OP(8'hCC), .CMD_REUSE(8'hDD),
        .ALU_LAT(ALU_LAT), .TMO_CYC(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    logic [7:0] exp_q[$];
    logic last_err, last_busy;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  fun;
        logic [15:0] res;
    } vec_t;
    vec_t vecs[10];

    // Registered ALU stand-in: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, others 0.
    function automatic logic [15:0] alu_f(logic [7:0] a, logic [7:0] b, logic [3:0] f);
        case (f)
            4'd0:    return {8'h0, a} + {8'h0, b};
            4'd1:    return {8'h0, a} - {8'h0, b};
            4'd2:    return {8'h0, a} * {8'h0, b};
            4'd3:    return {8'h0, a & b};
            4'd4:    return {8'h0, a | b};
            4'd5:    return {8'h0, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst)             bus.alu_out <= 16'h0;
        else if (bus.alu_en) bus.alu_out <= alu_f(bus.alu_a, bus.alu_b, bus.alu_fun);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.alu_en) en_cnt++;
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) chk("unexpected_tx", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
            else                   chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
        end
    end

    // Called at posedge+1; returns at posedge+1 with err/busy sampled during the byte cycle.
    task automatic send_byte(logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        last_err  = bus.err;
        last_busy = bus.busy;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_res(logic [15:0] r);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
    endtask

    task automatic wait_drain(string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_txv(string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.tx_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk(name, {31'h0, ok}, 32'h1);
    endtask

    initial begin
        int n;
        vecs[0] = '{8'h0F, 8'h03, 4'd0, 16'h0012};
        vecs[1] = '{8'hFF, 8'h02, 4'd2, 16'h01FE};
        vecs[2] = '{8'h10, 8'h20, 4'd1, 16'hFFF0};
        vecs[3] = '{8'hF0, 8'h3C, 4'd3, 16'h0030};
        vecs[4] = '{8'hF0, 8'h3C, 4'd4, 16'h00FC};
        vecs[5] = '{8'hF0, 8'h3C, 4'd5, 16'h00CC};
        vecs[6] = '{8'h12, 8'h34, 4'd15, 16'h0000};
        vecs[7] = '{8'hFF, 8'hFF, 4'd2, 16'hFE01};
        vecs[8] = '{8'hFF, 8'h01, 4'd0, 16'h0100};
        vecs[9] = '{8'h80, 8'h7F, 4'd1, 16'h0001};

        bus.rx_data  = 8'h0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {bus.tx_valid, bus.alu_en, bus.busy, bus.err, bus.tx_data,
                            bus.alu_a, bus.alu_b, 4'h0, bus.alu_fun}, 32'h0);
        @(posedge clk);
        #1;

        // Table: full CC frames; FUN byte high nibble is junk and must be ignored
        foreach (vecs[i]) begin
            en_cnt = 0;
            send_byte(8'hCC);
            send_byte(vecs[i].a);
            send_byte(vecs[i].b);
            push_res(vecs[i].res);
            send_byte({4'hA, vecs[i].fun});
            wait_drain("table_drain");
            chk("table_alu_en_cycles", en_cnt, ALU_LAT);
            chk("table_operands", {8'h0, bus.alu_a, bus.alu_b, 4'h0, bus.alu_fun},
                {8'h0, vecs[i].a, vecs[i].b, 4'h0, vecs[i].fun});
        end

        // DD reuses the A=FF, B=02 pair
        send_byte(8'hCC); send_byte(8'hFF); send_byte(8'h02);
        push_res(16'h01FE);
        send_byte(8'h02);
        wait_drain("reuse_first_drain");
        push_res(16'h00FD);
        send_byte(8'hDD);
        send_byte(8'h01);
        wait_drain("reuse_second_drain");
        chk("reuse_operands", {bus.alu_a, bus.alu_b}, 16'hFF02);

        // Unknown opcode
        send_byte(8'h55);
        chk("badop_err", last_err, 1);
        chk("badop_busy", last_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("badop_idle", {bus.busy, bus.tx_valid, bus.err}, 0);
        send_byte(8'hCC); send_byte(8'h0F); send_byte(8'h03);
        push_res(16'h0012);
        send_byte(8'h00);
        wait_drain("after_badop_drain");

        // Back-pressure in SEND_LO with a dropped RX byte
        bus.tx_ready = 1'b0;
        send_byte(8'hCC); send_byte(8'h0F); send_byte(8'h03);
        push_res(16'h0012);
        send_byte(8'h00);
        wait_txv("stall_txv");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {bus.tx_valid, bus.busy, bus.tx_data}, {2'b11, 8'h12});
            @(posedge clk);
            #1;
        end
        send_byte(8'h77);
        chk("drop_err", last_err, 1);
        @(negedge clk);
        chk("drop_state", {bus.tx_valid, bus.err, bus.tx_data}, {2'b10, 8'h12});
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b1;
        wait_drain("stall_drain");

        // Reset while SEND_HI is stalled, then DD must see A=B=0
        bus.tx_ready = 1'b0;
        send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF);
        push_res(16'h01FE);
        send_byte(8'h00);
        wait_txv("rst_txv");
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b0;
        chk("send_hi_byte", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h01});
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_abort", {bus.tx_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_fun}, 0);
        rst = 1'b0;
        exp_q.delete();
        bus.tx_ready = 1'b1;
        push_res(16'h0000);
        send_byte(8'hDD);
        send_byte(8'h00);
        wait_drain("reuse_after_rst_drain");

        // Stalled frame: CC, 01 then silence
        send_byte(8'hCC);
        send_byte(8'h01);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.err) n++;
        end
        @(posedge clk);
        #1;
`ifdef ALU_CTRL_TMO_EN
        chk("tmo_err_pulses", n, 1);
        chk("tmo_idle", {bus.busy, bus.alu_a}, {1'b0, 8'h01});
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h06);
        push_res(16'h000B);
        send_byte(8'h00);
        wait_drain("tmo_next_drain");
`else
        chk("no_tmo_err", n, 0);
        chk("no_tmo_busy", bus.busy, 1);
        send_byte(8'h02);
        push_res(16'h0003);
        send_byte(8'h00);
        wait_drain("no_tmo_drain");
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
